// File: rtl/frame_scheduler.sv
// Frame scheduler: walks a raster of screen coordinates into a ray pipeline, buffers
// the in-order shades and streams them out with line/frame markers.
module frame_scheduler #(
  parameter int H_RES       = 320,
  parameter int V_RES       = 240,
  parameter int FP_WIDTH    = 32,
  parameter int COLOR_WIDTH = 8,
  parameter int FIFO_DEPTH  = 16,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_gen,
  input  logic                   start,
  input  logic [FP_WIDTH-1:0]    x_start,
  input  logic [FP_WIDTH-1:0]    y_start,
  input  logic [FP_WIDTH-1:0]    x_step,
  input  logic [FP_WIDTH-1:0]    y_step,
  input  logic                   sdf_sel_in,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FP_WIDTH-1:0]    pix_screen_x,
  output logic [FP_WIDTH-1:0]    pix_screen_y,
  output logic                   pix_valid,
  output logic                   pix_sdf_sel,
  input  logic [COLOR_WIDTH-1:0] res_shade,
  input  logic                   res_valid,
  output logic [COLOR_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   m_tuser,
  output logic [1:0]             dbg_state,
  output logic [CNT_W-1:0]       dbg_credit
);

  // Handshakes: pix_valid is a one-cycle issue strobe with no ready; res_valid is
  // a one-cycle result strobe with no ready; m_t* is valid/ready, transfer when both high.
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [XW-1:0] XMAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] YMAX = YW'(V_RES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [FP_WIDTH-1:0]   xs_q, xs_d, xstep_q, xstep_d, ystep_q, ystep_d;
  logic [FP_WIDTH-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                  sel_q, sel_d;
  logic [XW-1:0]         ix_q, ix_d, ox_q, ox_d;
  logic [YW-1:0]         iy_q, iy_d, oy_q, oy_d;
  logic [CNT_W-1:0]      credit_q, credit_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [COLOR_WIDTH-1:0] mem [FIFO_DEPTH];

  logic issue, out_hs, last_issue, last_out, fifo_wr, fifo_full, fifo_empty;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign issue      = (state_q == RUN) && (credit_q < CNT_W'(FIFO_DEPTH));
  assign out_hs     = m_tvalid && m_tready;
  assign last_issue = issue && (ix_q == XMAX) && (iy_q == YMAX);
  assign last_out   = out_hs && (ox_q == XMAX) && (oy_q == YMAX);
  // A result with nothing in flight cannot belong to this frame; drop it.
  assign fifo_wr    = res_valid && (credit_q != '0) && !fifo_full;

  assign busy         = (state_q != IDLE);
  assign frame_done   = (state_q == DRAIN) && last_out;
  assign pix_valid    = issue;
  assign pix_screen_x = acc_x_q;
  assign pix_screen_y = acc_y_q;
  assign pix_sdf_sel  = sel_q;
  assign m_tvalid     = !fifo_empty;
  assign m_tdata      = m_tvalid ? mem[rd_ptr_q[AW-1:0]] : '0;
  assign m_tlast      = m_tvalid && (ox_q == XMAX);
  assign m_tuser      = m_tvalid && (ox_q == '0) && (oy_q == '0);
  assign dbg_state    = state_q;
  assign dbg_credit   = credit_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = RUN;
      RUN:     if (last_issue) state_d = DRAIN;
      DRAIN:   if (last_out)   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    xs_d    = xs_q;
    xstep_d = xstep_q;
    ystep_d = ystep_q;
    sel_d   = sel_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    ix_d    = ix_q;
    iy_d    = iy_q;
    if ((state_q == IDLE) && start) begin
      xs_d    = x_start;
      xstep_d = x_step;
      ystep_d = y_step;
      sel_d   = sdf_sel_in;
      acc_x_d = x_start;
      acc_y_d = y_start;
      ix_d    = '0;
      iy_d    = '0;
    end else if (issue) begin
      if (ix_q == XMAX) begin
        ix_d    = '0;
        acc_x_d = xs_q;
        acc_y_d = acc_y_q + ystep_q;
        iy_d    = (iy_q == YMAX) ? '0 : iy_q + 1'b1;
      end else begin
        ix_d    = ix_q + 1'b1;
        acc_x_d = acc_x_q + xstep_q;
      end
    end
  end

  always_comb begin
    ox_d     = ox_q;
    oy_d     = oy_q;
    credit_d = credit_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (out_hs) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (ox_q == XMAX) begin
        ox_d = '0;
        oy_d = (oy_q == YMAX) ? '0 : oy_q + 1'b1;
      end else begin
        ox_d = ox_q + 1'b1;
      end
    end
    if (fifo_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({issue, out_hs})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_gen) begin
    if (rst_gen) begin
      state_q  <= IDLE;
      xs_q     <= '0;
      xstep_q  <= '0;
      ystep_q  <= '0;
      sel_q    <= 1'b0;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      ix_q     <= '0;
      iy_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      credit_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      xstep_q  <= xstep_d;
      ystep_q  <= ystep_d;
      sel_q    <= sel_d;
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      ix_q     <= ix_d;
      iy_q     <= iy_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      credit_q <= credit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q[AW-1:0]] <= res_shade;
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: pipeline model with in-order latency, scoreboarded
// coordinate and output checks, stall, mid-frame start and reset scenarios.
module tb_frame_scheduler;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FW = 32;
  localparam int CW = 8;
  localparam int D  = 4;
  localparam int NW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_gen, start, sdf_sel_in, res_valid, m_tready;
  logic [FW-1:0] x_start, y_start, x_step, y_step;
  logic [CW-1:0] res_shade;
  logic          busy, frame_done, pix_valid, pix_sdf_sel, m_tvalid, m_tlast, m_tuser;
  logic [FW-1:0] pix_screen_x, pix_screen_y;
  logic [CW-1:0] m_tdata;
  logic [1:0]    dbg_state;
  logic [NW-1:0] dbg_credit;

  frame_scheduler #(.H_RES(H), .V_RES(V), .FP_WIDTH(FW), .COLOR_WIDTH(CW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_gen(rst_gen), .start(start),
    .x_start(x_start), .y_start(y_start), .x_step(x_step), .y_step(y_step),
    .sdf_sel_in(sdf_sel_in), .busy(busy), .frame_done(frame_done),
    .pix_screen_x(pix_screen_x), .pix_screen_y(pix_screen_y), .pix_valid(pix_valid),
    .pix_sdf_sel(pix_sdf_sel), .res_shade(res_shade), .res_valid(res_valid),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .dbg_state(dbg_state), .dbg_credit(dbg_credit)
  );

  always #5 clk = ~clk;

  // scoreboard state
  logic [63:0]   coord_q[$];
  logic [CW+1:0] exp_q[$];
  int            due_q[$];
  logic [CW-1:0] sh_q[$];
  int total = 0, bad = 0;
  int cyc = 0, last_due = 0, issue_cnt = 0, done_cnt = 0, credit_m = 0;
  int lat_mode = 0, rdy_mode = 0;
  logic rdy_fixed = 1'b1, exp_sel = 1'b0, prev_stall = 1'b0;
  logic [CW+1:0] prev_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] shade_f(input logic [FW-1:0] x, input logic [FW-1:0] y);
    return x[23:16] ^ {y[19:16], y[23:20]} ^ 8'h5a;
  endfunction

  // issue-side monitor + pipeline model (results return in issue order)
  always @(negedge clk) begin
    if (!rst_gen) begin
      if (pix_valid) begin
        int lat, due;
        logic [63:0] c;
        issue_cnt++;
        if (coord_q.size() == 0) chk("issue_extra", 64'(issue_cnt), 64'(0));
        else begin
          c = coord_q.pop_front();
          chk("pix_xy", {pix_screen_x, pix_screen_y}, c);
        end
        chk("pix_sel", 64'(pix_sdf_sel), 64'(exp_sel));
        lat = (lat_mode != 0) ? $urandom_range(1, 12) : 10;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        due_q.push_back(due);
        sh_q.push_back(shade_f(pix_screen_x, pix_screen_y));
      end else if (busy) begin
        chk("sel_hold", 64'(pix_sdf_sel), 64'(exp_sel));
      end
      if (frame_done) done_cnt++;
    end
  end

  // output-side monitor
  always @(negedge clk) begin
    if (!rst_gen) begin
      logic [CW+1:0] cur, e;
      cur = {m_tuser, m_tlast, m_tdata};
      chk("credit", 64'(dbg_credit), 64'(credit_m));
      if (m_tvalid && prev_stall) chk("stall_hold", 64'(cur), 64'(prev_out));
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("out_extra", 64'(cur), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("out_pix", 64'(cur), 64'(e));
        end
      end
      credit_m = credit_m + (pix_valid ? 1 : 0) - ((m_tvalid && m_tready) ? 1 : 0);
      prev_stall = m_tvalid && !m_tready;
      prev_out = cur;
    end
  end

  // pipeline result and ready driver
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_gen) res_valid = 1'b0;
    else begin
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        res_valid = 1'b1;
        res_shade = sh_q.pop_front();
        void'(due_q.pop_front());
      end else begin
        res_valid = 1'b0;
        res_shade = $urandom_range(0, 255);
      end
      m_tready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [FW-1:0] xs, input logic [FW-1:0] xst,
                             input logic [FW-1:0] ys, input logic [FW-1:0] yst, input logic sel);
    logic [FW-1:0] cx, cy;
    @(posedge clk); #1;
    x_start = xs; x_step = xst; y_start = ys; y_step = yst; sdf_sel_in = sel;
    exp_sel = sel;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        cx = xs + FW'(x) * xst;
        cy = ys + FW'(y) * yst;
        coord_q.push_back({cx, cy});
        exp_q.push_back({(x == 0 && y == 0), (x == H - 1), shade_f(cx, cy)});
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x_start = $urandom; x_step = $urandom; y_start = $urandom; y_step = $urandom;
    sdf_sel_in = ~sel;
  endtask

  task automatic wait_done(input string name, input bit poke);
    int n = 0;
    int d0 = done_cnt;
    bit seen = 0;
    while (n < 3000 && !seen) begin
      @(negedge clk);
      n++;
      if (frame_done) begin
        seen = 1;
        if (poke) start = 1'b1;
      end
    end
    chk({name, "_done_seen"}, 64'(seen), 64'(1));
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk({name, "_start_on_done_ignored"}, 64'(busy), 64'(0));
    end
    wait_cyc(15);
    chk({name, "_one_done"}, 64'(done_cnt - d0), 64'(1));
    chk({name, "_outs_drained"}, 64'(exp_q.size()), 64'(0));
    chk({name, "_issues_drained"}, 64'(coord_q.size()), 64'(0));
    chk({name, "_idle"}, 64'({busy, m_tvalid}), 64'(0));
  endtask

  task automatic check_reset(input string name);
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_frame_done"}, 64'(frame_done), 64'(0));
    chk({name, "_pix_valid"}, 64'(pix_valid), 64'(0));
    chk({name, "_m_tvalid"}, 64'(m_tvalid), 64'(0));
    chk({name, "_m_tlast"}, 64'(m_tlast), 64'(0));
    chk({name, "_m_tuser"}, 64'(m_tuser), 64'(0));
    chk({name, "_pix_xy"}, {pix_screen_x, pix_screen_y}, 64'(0));
    chk({name, "_pix_sel"}, 64'(pix_sdf_sel), 64'(0));
    chk({name, "_m_tdata"}, 64'(m_tdata), 64'(0));
    chk({name, "_state"}, 64'(dbg_state), 64'(0));
    chk({name, "_credit"}, 64'(dbg_credit), 64'(0));
  endtask

  task automatic do_reset();
    rst_gen = 1'b1;
    res_valid = 1'b0;
    #1;
    check_reset("rst");
    coord_q.delete(); exp_q.delete(); due_q.delete(); sh_q.delete();
    credit_m = 0;
    prev_stall = 1'b0;
    wait_cyc(2);
    @(posedge clk); #2;
    rst_gen = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst_gen = 1'b1; start = 1'b0; sdf_sel_in = 1'b0; res_valid = 1'b0; res_shade = '0;
    m_tready = 1'b1; x_start = '0; y_start = '0; x_step = '0; y_step = '0;
    wait_cyc(3);
    check_reset("init");
    @(posedge clk); #2;
    rst_gen = 1'b0;

    // 4x2 frame, fixed latency, ready high; mid-frame start with other params is ignored
    lat_mode = 0; rdy_mode = 0; rdy_fixed = 1'b1;
    start_frame(32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000, 32'h0001_0000, 1'b1);
    wait_cyc(3);
    x_start = 32'h1234_0000; sdf_sel_in = 1'b0; start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_done("frameA", 0);

    // output stalled: credits cap issue at FIFO depth, then release; start on done is ignored
    rdy_fixed = 1'b0;
    base = issue_cnt;
    start_frame(32'h0002_0000, 32'hFFFF_8000, 32'h0003_0000, 32'h0000_4000, 1'b0);
    wait_cyc(40);
    chk("stall_issue_cnt", 64'(issue_cnt - base), 64'(D));
    chk("stall_busy", 64'({busy, m_tvalid}), 64'(3));
    rdy_fixed = 1'b1;
    wait_done("frameB", 1);

    // random ready and random latency, back-to-back frames with wrap-around coordinates
    rdy_mode = 1; lat_mode = 1;
    start_frame(32'h7FFF_8000, 32'h0001_8000, 32'h0010_0000, 32'hFFF0_0000, 1'b0);
    wait_done("frameC0", 0);
    start_frame(32'hFFFE_0000, 32'h0003_0000, 32'h8000_0000, 32'h1234_5678, 1'b1);
    wait_done("frameC1", 0);
    for (int i = 0; i < 4; i++) begin
      start_frame($urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_done("frameCr", 0);
    end

    // reset mid-frame with results buffered, then a clean frame from (0,0)
    rdy_mode = 0; rdy_fixed = 1'b0; lat_mode = 0;
    start_frame(32'h0005_0000, 32'h0001_0000, 32'h0006_0000, 32'h0001_0000, 1'b1);
    wait_cyc(12);
    chk("pre_rst_fifo_nonempty", 64'(m_tvalid), 64'(1));
    @(posedge clk); #2;
    do_reset();
    rdy_mode = 1; lat_mode = 1;
    start_frame(32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000, 1'b0);
    wait_done("frameR", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
